// File: rtl/axi_line_write_master.sv
// axi_line_write_master: writes one dirty cache line to memory as a single
// AXI4 INCR write burst (AW, W beats, B) and pulses completion with an error flag.
// Build option: define AXI_WRITE_AW_W_OVERLAP_EN to issue AW and W concurrently.
module axi_line_write_master #(
  parameter int         ADDR_WIDTH      = 32,
  parameter int         AXI_DATA_WIDTH  = 32,
  parameter int         _REQ_DATA_WIDTH = 256,
  parameter logic [7:0] _AW_LEN         = 8'h7,
  parameter logic [2:0] _AW_SIZE        = 3'b010,
  parameter logic [1:0] _AW_BURST       = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write_req_valid,
  output logic                          write_req_ready,
  input  logic [ADDR_WIDTH-1:0]         write_addr,
  input  logic [_REQ_DATA_WIDTH-1:0]    write_data,
  output logic                          write_resp_valid,
  output logic                          write_resp_err,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [AXI_DATA_WIDTH-1:0]     wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  output logic                          wlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp
);

  localparam int unsigned NBEATS   = int'(_AW_LEN) + 1;
  localparam int unsigned OFF_BITS = $clog2(_REQ_DATA_WIDTH / 8);
  localparam int unsigned CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(_AW_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
  typedef enum logic [1:0] {S_IDLE, S_AW_W, S_B} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;
`endif

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_DATA_WIDTH-1:0] beats_q [NBEATS];
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic                      accept;
  logic                      beat_hs;
  logic                      last_beat;
  logic                      b_hs;
  logic                      bresp_unused;

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
  logic aw_done_q;
  logic w_done_q;
`endif

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign accept    = write_req_valid & write_req_ready;
  assign beat_hs   = wvalid & wready;
  assign b_hs      = bvalid & bready;

  assign awaddr    = addr_q;
  assign awlen     = _AW_LEN;
  assign awsize    = _AW_SIZE;
  assign awburst   = _AW_BURST;
  assign wdata     = beats_q[beat_cnt_q];
  assign wstrb     = '1;
  assign wlast     = wvalid & last_beat;

  assign write_resp_valid = resp_valid_q;
  assign write_resp_err   = resp_err_q;

  // Only BRESP[1] distinguishes error from OKAY/EXOKAY.
  assign bresp_unused = bresp[0];

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and channel handshake outputs, decoded from the current state.
  always_comb begin
    state_d         = state_q;
    write_req_ready = 1'b0;
    awvalid         = 1'b0;
    wvalid          = 1'b0;
    bready          = 1'b0;
    case (state_q)
      S_IDLE: begin
        write_req_ready = 1'b1;
        if (write_req_valid) begin
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
          state_d = S_AW_W;
`else
          state_d = S_AW;
`endif
        end
      end
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
      // AW and W complete independently; leave once both are done, in either order.
      S_AW_W: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | awready) & (w_done_q | (wready & last_beat))) begin
          state_d = S_B;
        end
      end
`else
      S_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        wvalid = 1'b1;
        if (wready & last_beat) begin
          state_d = S_B;
        end
      end
`endif
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the line address and beat counter; step the counter per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else if (accept) begin
      addr_q     <= write_addr & ADDR_MASK;
      beat_cnt_q <= '0;
    end else if (beat_hs && !last_beat) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  // Line data captured beat-wise on accept.
  for (genvar g = 0; g < NBEATS; g++) begin : g_beat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        beats_q[g] <= '0;
      end else if (accept) begin
        beats_q[g] <= write_data[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // Completion pulse, registered so it coincides with ready in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= b_hs;
      resp_err_q   <= b_hs & bresp[1];
    end
  end

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
  // Per-channel completion flags for the overlapped AW/W phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_done_q <= 1'b1;
      end
      if (beat_hs && last_beat) begin
        w_done_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_line_write_master.sv
// Self-checking bench for axi_line_write_master: the bench acts as AXI slave and
// compares every burst against a line-level model (aligned address, ordered beats).
`timescale 1ns/1ps
module tb_axi_line_write_master;

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [31:0] OFF_MASK = 32'h0000_001F;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_req_valid;
  logic         write_req_ready;
  logic [31:0]  write_addr;
  logic [255:0] write_data;
  logic         write_resp_valid;
  logic         write_resp_err;
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [1:0]   bresp;

  always #5 clk = ~clk;

  axi_line_write_master #(
    .ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    ._REQ_DATA_WIDTH(256),
    ._AW_LEN(8'h7),
    ._AW_SIZE(3'b010),
    ._AW_BURST(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_req_valid(write_req_valid), .write_req_ready(write_req_ready),
    .write_addr(write_addr), .write_data(write_data),
    .write_resp_valid(write_resp_valid), .write_resp_err(write_resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] cur_words [8];

  int          aw_edge, b_edge, resp_edge, resp_cnt, accepts;
  int          viol_aw, viol_early, viol_hold, viol_strb;
  logic        resp_err_seen, ready_at_resp;
  logic [31:0] aw_addr_seen;
  logic [12:0] aw_ctl_seen;
  logic [31:0] beat_q [$];
  logic        last_q [$];
  int          beat_edge_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One burst with the bench acting as slave; edges counted from the accept edge (0).
  task automatic run_burst(input logic [31:0] addr, input int aw_delay, input int wmode,
                           input logic [1:0] resp, input bit hold_req);
    logic [255:0] line;
    logic [31:0]  exp_awaddr;
    logic [31:0]  prev_wdata;
    logic         prev_wlast;
    int           e, aw_wait, tail;
    bit           last_done, prev_stall;
    exp_awaddr = addr & ~OFF_MASK;
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = cur_words[k];
    aw_edge = -1; b_edge = -1; resp_edge = -1; resp_cnt = 0;
    viol_aw = 0; viol_early = 0; viol_hold = 0; viol_strb = 0;
    resp_err_seen = 1'b0; ready_at_resp = 1'b0; aw_addr_seen = '0; aw_ctl_seen = '0;
    beat_q.delete(); last_q.delete(); beat_edge_q.delete();
    @(negedge clk);
    write_req_valid = 1'b1;
    write_addr      = addr;
    write_data      = line;
    accepts = write_req_ready ? 1 : 0;
    e = -1; aw_wait = 0; tail = 0; last_done = 0; prev_stall = 0;
    prev_wdata = '0; prev_wlast = 1'b0;
    while (e < 80 && tail < 3) begin
      @(negedge clk);
      e++;
      if (!hold_req) begin
        write_req_valid = 1'b0;
      end else if (write_req_valid) begin
        write_addr = $urandom;
        for (int k = 0; k < 8; k++) write_data[k*32 +: 32] = $urandom;
      end
      if (write_resp_valid) begin
        resp_cnt++;
        resp_edge       = e;
        resp_err_seen   = write_resp_err;
        ready_at_resp   = write_req_ready;
        write_req_valid = 1'b0;
      end
      if (resp_cnt > 0) tail++;
      if (write_req_valid && write_req_ready) accepts++;
      if (awvalid && awaddr !== exp_awaddr) viol_aw++;
      if (!OVL && wvalid && aw_edge < 0) viol_early++;
      if (prev_stall && (wvalid !== 1'b1 || wdata !== prev_wdata || wlast !== prev_wlast)) viol_hold++;
      if (wvalid && wstrb !== 4'hF) viol_strb++;
      awready = awvalid && (aw_wait >= aw_delay);
      if (awvalid) aw_wait++;
      if (wmode == 0)      wready = 1'b1;
      else if (wmode == 1) wready = (e % 2 == 0);
      else                 wready = 1'($urandom_range(0, 1));
      bvalid = last_done && (b_edge < 0);
      bresp  = bvalid ? resp : 2'b00;
      if (awvalid && awready) begin
        aw_edge      = e + 1;
        aw_addr_seen = awaddr;
        aw_ctl_seen  = {awlen, awsize, awburst};
      end
      if (wvalid && wready) begin
        beat_q.push_back(wdata);
        last_q.push_back(wlast);
        beat_edge_q.push_back(e + 1);
        if (wlast) last_done = 1;
      end
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      prev_wlast = wlast;
      if (bvalid && bready) b_edge = e + 1;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; write_req_valid = 1'b0;
  endtask

  // Compare the recorded burst with the line model.
  task automatic check_burst(input string tag, input logic [31:0] addr,
                             input logic [1:0] resp, input bit zero_wait);
    check({tag, ".accepts"}, accepts, 1);
    check({tag, ".aw_seen"}, aw_edge >= 0, 1);
    check({tag, ".awaddr"}, aw_addr_seen, addr & ~OFF_MASK);
    check({tag, ".aw_len_size_burst"}, aw_ctl_seen, {8'h07, 3'b010, 2'b01});
    check({tag, ".awaddr_stable"}, viol_aw, 0);
    check({tag, ".w_before_aw"}, viol_early, 0);
    check({tag, ".w_held_on_stall"}, viol_hold, 0);
    check({tag, ".wstrb"}, viol_strb, 0);
    check({tag, ".beat_count"}, beat_q.size(), 8);
    if (beat_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("%s.beat%0d_data", tag, k), beat_q[k], cur_words[k]);
        check($sformatf("%s.beat%0d_last", tag, k), last_q[k], k == 7);
      end
    end
    check({tag, ".resp_pulses"}, resp_cnt, 1);
    check({tag, ".resp_err"}, resp_err_seen, resp[1]);
    check({tag, ".resp_after_b"}, resp_edge, b_edge);
    check({tag, ".ready_with_resp"}, ready_at_resp, 1'b1);
    if (zero_wait && beat_edge_q.size() > 0) begin
      check({tag, ".aw_edge"}, aw_edge, 1);
      check({tag, ".first_beat_edge"}, beat_edge_q[0], OVL ? 1 : 2);
      check({tag, ".resp_edge"}, resp_edge, OVL ? 9 : 10);
    end
  endtask

  task automatic reset_mid_burst();
    logic [255:0] line;
    int  n, acc, pulses, busy;
    bit  found;
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = cur_words[k];
    @(negedge clk);
    write_req_valid = 1'b1; write_addr = 32'h0000_8040; write_data = line;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    @(negedge clk);
    write_req_valid = 1'b0;
    n = 0; acc = 0; found = 0;
    while (n < 40 && !found) begin
      if (wvalid && acc == 3) begin
        found = 1;
      end else begin
        if (wvalid) acc++;
        @(negedge clk);
        n++;
      end
    end
    check("rst.beat3_reached", found, 1'b1);
    check("rst.beat3_data", wdata, cur_words[3]);
    #2 rst_n = 1'b0;
    #1;
    check("rst.valids_drop", {awvalid, wvalid, bready, write_resp_valid}, 4'b0000);
    check("rst.ready_in_reset", write_req_ready, 1'b1);
    awready = 1'b0; wready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (write_resp_valid) pulses++;
      if (awvalid || wvalid || bready || !write_req_ready) busy++;
    end
    check("rst.no_resp_pulse", pulses, 0);
    check("rst.idle_after_release", busy, 0);
  endtask

  task automatic fill_random_words();
    for (int k = 0; k < 8; k++) cur_words[k] = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    write_req_valid = 1'b0; write_addr = '0; write_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("reset.ready", write_req_ready, 1'b1);
    check("reset.flags", {awvalid, wvalid, bready, write_resp_valid, write_resp_err, wlast}, 6'b0);
    check("reset.awaddr", awaddr, 32'h0);
    check("reset.wdata", wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) cur_words[k] = 32'h1111_1111 * (k + 1);
    run_burst(32'h0000_1234, 0, 0, 2'b00, 1'b0);
    check_burst("zero_wait", 32'h0000_1234, 2'b00, 1'b1);
    check("zero_wait.awaddr_value", aw_addr_seen, 32'h0000_1220);

    fill_random_words();
    run_burst(32'hA5A5_0F3C, 5, 0, 2'b00, 1'b0);
    check_burst("aw_stall", 32'hA5A5_0F3C, 2'b00, 1'b0);
    check("aw_stall.aw_edge", aw_edge, 6);
    check("aw_stall.first_beat_edge", beat_edge_q.size() > 0 ? beat_edge_q[0] : -1, OVL ? 1 : 7);

    fill_random_words();
    run_burst(32'h0001_0000, 0, 1, 2'b00, 1'b0);
    check_burst("wready_toggle", 32'h0001_0000, 2'b00, 1'b0);

    fill_random_words();
    run_burst(32'h0002_0044, 0, 0, 2'b10, 1'b0);
    check_burst("slverr", 32'h0002_0044, 2'b10, 1'b0);
    fill_random_words();
    run_burst(32'h0002_0080, 0, 0, 2'b00, 1'b0);
    check_burst("after_err", 32'h0002_0080, 2'b00, 1'b0);

    fill_random_words();
    run_burst(32'hDEAD_BEEF, 1, 2, 2'b00, 1'b1);
    check_burst("req_held", 32'hDEAD_BEEF, 2'b00, 1'b0);

    fill_random_words();
    reset_mid_burst();
    fill_random_words();
    run_burst(32'h0000_3000, 0, 0, 2'b01, 1'b0);
    check_burst("post_reset", 32'h0000_3000, 2'b01, 1'b1);

    for (int t = 0; t < 8; t++) begin
      logic [31:0] a;
      logic [1:0]  r;
      a = $urandom;
      r = 2'($urandom_range(0, 3));
      fill_random_words();
      run_burst(a, int'($urandom_range(0, 3)), 2, r, 1'($urandom_range(0, 1)));
      check_burst($sformatf("rand%0d", t), a, r, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
